if_fetch: RTL and testbench

- Instruction-fetch stage; sits directly upstream of the decode stage.
- Owns the PC and fetches instructions from the instruction-memory controller over a req/ack handshake.
- Presents the instruction word and the next PC (PC+4) to decode.
- Absorbs decode stalls through a one-entry skid buffer, and restarts from a new PC on a branch or jump redirect.

---
 rtl/if_pkg.sv | 10 +
 rtl/if_skid_buffer.sv | 22 ++
 rtl/if_fetch.sv | 83 ++++++++
 tb/tb_if_fetch.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// if_pkg: shared types and defaults for the instruction-fetch stage.
package if_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] npc;
  } fetch_word_t;
endpackage

// File: rtl/if_skid_buffer.sv
// if_skid_buffer: one-entry holding register with load/drain/clear; clear wins over load.
module if_skid_buffer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      valid <= clear ? 1'b0 : load ? 1'b1 : drain ? 1'b0 : valid;
      if (load && !clear) q <= d;
    end
endmodule

// File: rtl/if_fetch.sv
// if_fetch: PC owner and instruction fetch with skid-buffered stall and redirect/drop handling.
// Optional IF_ALIGN_CHECK_EN adds a sticky misalign output for unaligned redirect targets.
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic [31:0] npc_o,
  output logic        ins_valid
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);
  state_t state, state_n;
  fetch_word_t w, skid_q;
  logic [31:0] pc, drop_addr, target;
  logic drop, skid_valid, acc, halted;
`ifdef IF_ALIGN_CHECK_EN
  assign target = redirect_pc;
  assign halted = misalign;
  always_ff @(posedge clk or negedge rst)
    if (!rst) misalign <= 1'b0;
    else if (redirect) misalign <= |redirect_pc[1:0];
`else
  assign target = redirect_pc & ~32'h3;
  assign halted = 1'b0;
`endif
  // an abandoned request keeps its original address until the memory acks it
  assign imem_req  = state == S_FETCH && !skid_valid && (drop || !halted);
  assign imem_addr = drop ? drop_addr : pc;
  assign acc       = imem_req && imem_ack && !drop && !redirect;
  assign w         = {imem_rdata, pc + 32'd4};
  if_skid_buffer #(.WIDTH(64)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (stall && acc),
    .drain (!stall && skid_valid),
    .clear (redirect),
    .d     (w),
    .q     (skid_q),
    .valid (skid_valid)
  );
  always_comb
    state_n = state == S_IDLE ? S_FETCH :
              redirect ? S_FETCH :
              (state == S_FETCH && stall && acc) ? S_HOLD :
              (state == S_HOLD && !stall) ? S_FETCH : state;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      drop_addr <= '0;
      ins       <= NOP_WORD;
      npc_o     <= '0;
      ins_valid <= 1'b0;
    end else begin
      state <= state_n;
      drop  <= redirect ? imem_req && !imem_ack : drop && !imem_ack;
      if (redirect && !drop) drop_addr <= imem_addr;
      pc <= redirect ? target : acc ? w.npc : pc;
      if (redirect || (!stall && !skid_valid && !acc)) begin
        ins       <= NOP_WORD;
        ins_valid <= 1'b0;
      end else if (!stall) begin
        ins       <= skid_valid ? skid_q.ins : w.ins;
        npc_o     <= skid_valid ? skid_q.npc : w.npc;
        ins_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: scoreboard bench; expected instruction stream is derived from redirect targets.
module tb_if_fetch;
  logic clk = 0, rst = 0, stall = 0, redirect = 0, imem_ack = 0;
  logic [31:0] redirect_pc = 0, imem_rdata = 0;
  logic imem_req, ins_valid;
  logic [31:0] imem_addr, ins, npc_o;
`ifdef IF_ALIGN_CHECK_EN
  logic misalign;
`endif
  int total = 0, bad = 0, consumed = 0;
  int mode = 0, wcnt = 0, cur_lat = 0;
  logic [63:0] exp_q[$];
  logic [31:0] push_pc = 32'h8000_0000, old, saved;
  bit hold_q = 0, pend = 0, found;
  logic [31:0] pend_addr = 0;

  if_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ins(ins), .npc_o(npc_o), .ins_valid(ins_valid)
`ifdef IF_ALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0] ^ 16'h3C5A, ~a[31:16]};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic refill();
    while (!hold_q && exp_q.size() < 32) begin
      exp_q.push_back({mem_word(push_pc), push_pc + 32'd4});
      push_pc += 32'd4;
    end
  endtask

  task automatic flush(logic [31:0] t);
    exp_q.delete();
    push_pc = t;
    refill();
  endtask

  task automatic step();
    @(negedge clk);
    refill();
  endtask

  task automatic do_redirect(logic [31:0] p, logic [31:0] t);
    redirect = 1;
    redirect_pc = p;
    flush(t);
  endtask

  // memory controller model: mode 0 = same-cycle ack, 1 = ack on 3rd cycle, 2 = random 0..3 waits
  always @(negedge clk) begin
    if (!rst || !imem_req) begin
      imem_ack = 0;
      wcnt = 0;
    end else if (wcnt >= cur_lat) begin
      imem_ack = 1;
      imem_rdata = mem_word(imem_addr);
      wcnt = 0;
      cur_lat = mode == 0 ? 0 : mode == 1 ? 2 : int'($urandom_range(0, 3));
    end else begin
      imem_ack = 0;
      wcnt++;
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst) begin
      if (pend) begin
        chk("req_held", imem_req, 1);
        chk("addr_held", imem_addr, pend_addr);
      end
      pend = imem_req && !imem_ack;
      pend_addr = imem_addr;
      if (ins_valid && !stall && !redirect) begin
        consumed++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stream: unexpected ins %h npc %h", ins, npc_o);
        end else chk("stream", {ins, npc_o}, exp_q.pop_front());
      end
    end else pend = 0;
  end

  initial begin
    repeat (3) step();
    #2;
    chk("rst_out", {ins, npc_o, ins_valid, imem_req}, 66'h0);
    flush(32'h8000_0000);
    step(); rst = 1;
    step(); #2 chk("addr0", {imem_req, imem_addr}, {1'b1, 32'h8000_0000});
    step(); #2 chk("addr1", {imem_req, imem_addr}, {1'b1, 32'h8000_0004});
    chk("first_ins", {ins_valid, ins, npc_o}, {1'b1, mem_word(32'h8000_0000), 32'h8000_0004});
    step(); #2 chk("addr2", {imem_req, imem_addr}, {1'b1, 32'h8000_0008});
    repeat (2) step();
    step(); stall = 1;
    #2 chk("stall_ack", {imem_req, imem_ack}, 2'b11);
    saved = ins;
    repeat (2) begin
      step(); #2 chk("stall_noreq", imem_req, 0);
      chk("stall_hold", ins, saved);
    end
    step(); stall = 0;
    repeat (4) step();
    step(); do_redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8);
    step(); redirect = 0;
    #2 chk("wrap_a", {imem_req, imem_addr}, {1'b1, 32'hFFFF_FFF8});
    step(); #2 chk("wrap_b", {imem_req, imem_addr}, {1'b1, 32'hFFFF_FFFC});
    step(); #2 chk("wrap_c", {imem_req, imem_addr}, {1'b1, 32'h0000_0000});
    chk("wrap_npc", {ins_valid, ins, npc_o}, {1'b1, mem_word(32'hFFFF_FFFC), 32'h0});
    step(); stall = 1; do_redirect(32'h8000_0100, 32'h8000_0100);
    #2 chk("rack_ack", {imem_req, imem_ack}, 2'b11);
    step(); stall = 0; redirect = 0;
    #2 chk("rack_out", {ins, ins_valid}, 33'h0);
    chk("rack_next", {imem_req, imem_addr}, {1'b1, 32'h8000_0100});
    repeat (3) step();
`ifdef IF_ALIGN_CHECK_EN
    step(); hold_q = 1; exp_q.delete(); redirect = 1; redirect_pc = 32'h8000_0102;
    repeat (3) begin
      step(); redirect = 0;
      #2 chk("mis_set", {misalign, imem_req}, 2'b10);
    end
    step(); hold_q = 0; do_redirect(32'h8000_0200, 32'h8000_0200);
    step(); redirect = 0;
    #2 chk("mis_clr", {misalign, imem_req, imem_addr}, {2'b01, 32'h8000_0200});
`else
    step(); do_redirect(32'h8000_0102, 32'h8000_0100);
    step(); redirect = 0;
    #2 chk("low_bits", {imem_req, imem_addr}, {1'b1, 32'h8000_0100});
`endif
    repeat (3) step();
    mode = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(); #2 found = imem_req && !imem_ack;
    end
    chk("wait_seen", found, 1);
    old = imem_addr;
    step(); do_redirect(32'h8000_0100, 32'h8000_0100);
    #2 chk("drop_hold", {imem_req, imem_ack, imem_addr}, {2'b10, old});
    step(); redirect = 0;
    #2 chk("drop_ack", {imem_req, imem_ack, imem_addr}, {2'b11, old});
    step(); #2 chk("drop_bubble", ins_valid, 0);
    chk("drop_next", {imem_req, imem_addr}, {1'b1, 32'h8000_0100});
    repeat (5) step();
    mode = 2;
    for (int i = 0; i < 800; i++) begin
      step();
      stall = $urandom_range(0, 9) < 3;
      if ($urandom_range(0, 19) == 0) begin
        old = 32'h8000_0000 | ($urandom_range(0, 1023) << 2);
        do_redirect(old, old);
      end else redirect = 0;
    end
    step(); stall = 0; redirect = 0;
    repeat (10) step();
    chk("progress", consumed > 100, 1);
    mode = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(); #2 found = imem_req && !imem_ack;
    end
    chk("wait_seen2", found, 1);
    #1 rst = 0;
    #1 chk("async_rst", {imem_req, ins_valid, ins, npc_o}, 66'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
